systolic_array: RTL and testbench

- 8x8 weight-stationary systolic matrix-vector engine for the accelerator datapath.
- Weights are loaded row by row over the shared 64-bit `inputs` bus.
- Activation vectors are then streamed in, and each produces one 8-lane result vector on `outputs`.
- Downstream backpressure arrives on `design_busy`; results are flagged with `activations_valid`.

---
 rtl/systolic_array.sv | 171 +++++++++++++++++
 tb/tb_systolic_array.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/systolic_array.sv
// 8x8 weight-stationary systolic matrix-vector engine.
// Weights load row by row; activation vectors stream through a skewed PE grid
// and emerge deskewed, saturated to int8, 2N advancing cycles after acceptance.
module systolic_array #(
  parameter int unsigned N      = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 19
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                load,
  input  logic [N*DATA_W-1:0] inputs,
  input  logic                array_start,
  input  logic                design_busy,
  output logic                array_busy,
  output logic [N*DATA_W-1:0] outputs,
  output logic                activations_valid
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned LAT    = 2 * N;
  localparam int unsigned PTR_W  = $clog2(N);
  localparam int unsigned CNT_W  = $clog2(LAT + 2);
  localparam logic signed [ACC_W-1:0] SMAX = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SMIN = ACC_W'(-(1 << (DATA_W - 1)));

  logic signed [DATA_W-1:0] w_q      [N][N];
  logic [PTR_W-1:0]         ptr_q;
  logic signed [DATA_W-1:0] sk_out   [N];
  logic signed [DATA_W-1:0] act_q    [N][N];
  logic signed [DATA_W-1:0] act_in   [N][N];
  logic signed [ACC_W-1:0]  psum_q   [N][N];
  logic signed [ACC_W-1:0]  psum_in  [N][N];
  logic signed [ACC_W-1:0]  psum_d   [N][N];
  logic signed [ACC_W-1:0]  col_out  [N];
  logic [LAT-1:0]           v_q;
  logic                     valid_q;
  logic [N*DATA_W-1:0]      out_q;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     busy_q;

  logic adv_c, accept_c, load_ok_c, consume_c;

  assign adv_c     = !design_busy;
  assign accept_c  = array_start && adv_c;
  assign load_ok_c = load && !array_start && !busy_q;
  assign consume_c = valid_q && adv_c;

  assign array_busy        = busy_q;
  assign outputs           = out_q;
  assign activations_valid = valid_q;

  function automatic logic [DATA_W-1:0] sat(input logic signed [ACC_W-1:0] x);
    if (x > SMAX)      return SMAX[DATA_W-1:0];
    else if (x < SMIN) return SMIN[DATA_W-1:0];
    else               return x[DATA_W-1:0];
  endfunction

  // Weight row write; ptr advances only on accepted loads (N is a power of two, so it wraps).
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) w_q[i][j] <= '0;
      ptr_q <= '0;
    end else if (load_ok_c) begin
      for (int j = 0; j < N; j++) w_q[ptr_q][j] <= $signed(inputs[j*DATA_W +: DATA_W]);
      ptr_q <= ptr_q + PTR_W'(1);
    end
  end

  // Input skew: lane i is delayed i extra cycles so it meets its partial sum.
  for (genvar gi = 0; gi < N; gi++) begin : g_skew
    logic signed [DATA_W-1:0] sk_q [gi+1];
    // Skew shift chain for lane gi; bubbles carry zero.
    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        for (int k = 0; k <= gi; k++) sk_q[k] <= '0;
      end else if (adv_c) begin
        sk_q[0] <= accept_c ? $signed(inputs[gi*DATA_W +: DATA_W]) : '0;
        for (int k = 1; k <= gi; k++) sk_q[k] <= sk_q[k-1];
      end
    end
    assign sk_out[gi] = sk_q[gi];
  end

  // PE operands: activations flow east, partial sums flow south.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      act_in[i][0] = sk_out[i];
      for (int j = 1; j < N; j++) act_in[i][j] = act_q[i][j-1];
    end
    for (int j = 0; j < N; j++) begin
      psum_in[0][j] = '0;
      for (int i = 1; i < N; i++) psum_in[i][j] = psum_q[i-1][j];
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        psum_d[i][j] = psum_in[i][j] +
                       ACC_W'(PROD_W'(act_in[i][j]) * PROD_W'(w_q[i][j]));
  end

  // PE grid registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          act_q[i][j]  <= '0;
          psum_q[i][j] <= '0;
        end
    end else if (adv_c) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          act_q[i][j]  <= act_in[i][j];
          psum_q[i][j] <= psum_d[i][j];
        end
    end
  end

  // Output deskew: column j waits N-1-j cycles so all lanes align.
  for (genvar gj = 0; gj < N; gj++) begin : g_col
    localparam int unsigned D = N - 1 - gj;
    if (D == 0) begin : g_direct
      assign col_out[gj] = psum_q[N-1][gj];
    end else begin : g_dsk
      logic signed [ACC_W-1:0] dsk_q [D];
      // Deskew shift chain for column gj.
      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          for (int k = 0; k < D; k++) dsk_q[k] <= '0;
        end else if (adv_c) begin
          dsk_q[0] <= psum_q[N-1][gj];
          for (int k = 1; k < D; k++) dsk_q[k] <= dsk_q[k-1];
        end
      end
      assign col_out[gj] = dsk_q[D-1];
    end
  end

  // Valid tracking shift and saturating output register; both hold under stall.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      v_q     <= '0;
      valid_q <= 1'b0;
      out_q   <= '0;
    end else if (adv_c) begin
      v_q     <= {v_q[LAT-2:0], accept_c};
      valid_q <= v_q[LAT-1];
      if (v_q[LAT-1])
        for (int j = 0; j < N; j++) out_q[j*DATA_W +: DATA_W] <= sat(col_out[j]);
    end
  end

  // In-flight count: accepted but not yet consumed.
  always_comb begin
    cnt_d = cnt_q;
    if (accept_c && !consume_c)      cnt_d = cnt_q + CNT_W'(1);
    else if (!accept_c && consume_c) cnt_d = cnt_q - CNT_W'(1);
  end

  // Count and registered busy flag.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= (cnt_d != '0);
    end
  end

endmodule

// File: tb/tb_systolic_array.sv
// Scoreboard bench for systolic_array: a matrix-vector reference model predicts
// each result and its arrival time; a negedge monitor compares what appears.
module tb_systolic_array;

  logic        clk = 1'b0;
  logic        n_rst, load, array_start, design_busy;
  logic [63:0] inputs, outputs;
  logic        array_busy, activations_valid;

  always #5 clk = ~clk;

  systolic_array dut (
    .clk(clk), .n_rst(n_rst), .load(load), .inputs(inputs),
    .array_start(array_start), .design_busy(design_busy),
    .array_busy(array_busy), .outputs(outputs),
    .activations_valid(activations_valid)
  );

  typedef struct {
    logic [63:0] data;
    int          stamp;
  } exp_t;

  int          errors = 0;
  int          checks = 0;
  int          mw [8][8];
  int          mptr = 0;
  int          adv_cnt = 0;
  int          m_stamps [$];
  exp_t        sb [$];
  logic [63:0] last_out = '0;
  bit          busy_prev;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Plain matrix-vector product with int8 saturation.
  function automatic logic [63:0] model_result(input logic [63:0] a);
    logic [63:0] r;
    int s, ai;
    r = '0;
    for (int j = 0; j < 8; j++) begin
      s = 0;
      for (int i = 0; i < 8; i++) begin
        ai = int'($signed(a[8*i +: 8]));
        s += ai * mw[i][j];
      end
      if (s > 127) s = 127;
      if (s < -128) s = -128;
      r[8*j +: 8] = 8'(s);
    end
    return r;
  endfunction

  // Reference model: advancing-cycle clock, weight store, in-flight list.
  always @(posedge clk) begin
    if (n_rst) begin
      busy_prev = (m_stamps.size() != 0);
      if (!design_busy) begin
        if (m_stamps.size() != 0 && m_stamps[0] + 16 == adv_cnt) void'(m_stamps.pop_front());
        adv_cnt++;
      end
      if (array_start && !design_busy) begin
        m_stamps.push_back(adv_cnt);
        sb.push_back('{model_result(inputs), adv_cnt});
      end else if (load && !array_start && !busy_prev) begin
        for (int j = 0; j < 8; j++) mw[mptr][j] = int'($signed(inputs[8*j +: 8]));
        mptr = (mptr + 1) % 8;
      end
    end
  end

  // Monitor: busy flag, result data/latency, and hold behaviour.
  always @(negedge clk) begin
    if (n_rst) begin
      chk("array_busy", {63'b0, array_busy}, {63'b0, m_stamps.size() != 0});
      if (activations_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", {63'b0, activations_valid}, 64'd0);
        end else begin
          chk("result", outputs, sb[0].data);
          if (!design_busy) begin
            chk("latency", 64'(adv_cnt), 64'(sb[0].stamp + 16));
            last_out = sb[0].data;
            void'(sb.pop_front());
          end
        end
      end else begin
        chk("idle_hold", outputs, last_out);
      end
    end
  end

  task automatic step(input logic ld, input logic st, input logic bz, input logic [63:0] d);
    load = ld; array_start = st; design_busy = bz; inputs = d;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 64'h0);
  endtask

  task automatic reset_mid();
    #2 n_rst = 1'b0;
    #1;
    chk("rst_outputs", outputs, 64'h0);
    chk("rst_valid", {63'b0, activations_valid}, 64'd0);
    chk("rst_busy", {63'b0, array_busy}, 64'd0);
    sb.delete();
    m_stamps.delete();
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) mw[i][j] = 0;
    mptr = 0;
    last_out = '0;
    @(posedge clk); #1;
    n_rst = 1'b1;
  endtask

  task automatic load_test_weights();
    for (int r = 0; r < 6; r++) step(1'b1, 1'b0, 1'b0, {8{8'(r + 1)}});
    step(1'b1, 1'b0, 1'b0, 64'h0707_0709_0707_0707);
    step(1'b1, 1'b0, 1'b0, {8{8'h01}});
  endtask

  initial begin
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) mw[i][j] = 0;
    n_rst = 1'b0; load = 1'b0; array_start = 1'b0; design_busy = 1'b0; inputs = '0;
    #2;
    chk("init_outputs", outputs, 64'h0);
    chk("init_valid", {63'b0, activations_valid}, 64'd0);
    chk("init_busy", {63'b0, array_busy}, 64'd0);
    @(posedge clk); #1;
    n_rst = 1'b1;

    // Directed weights; single vector of ones
    load_test_weights();
    step(1'b0, 1'b1, 1'b0, {8{8'h01}});
    idle(20);

    // Two vectors five cycles apart
    step(1'b0, 1'b1, 1'b0, {8{8'h02}});
    idle(4);
    step(1'b0, 1'b1, 1'b0, {8{8'h03}});
    idle(22);

    // Saturation
    step(1'b0, 1'b1, 1'b0, {8{8'h05}});
    idle(20);

    // Back-to-back starts, then a 4-cycle stall across the valid window
    step(1'b0, 1'b1, 1'b0, {8{8'h01}});
    step(1'b0, 1'b1, 1'b0, {8{8'h02}});
    step(1'b0, 1'b1, 1'b0, {8{8'hFF}});
    idle(14);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1, 64'h0);
    idle(20);

    // Ignored loads: while busy, and alongside a start
    step(1'b0, 1'b1, 1'b0, {8{8'h01}});
    step(1'b1, 1'b0, 1'b0, {8{8'h40}});
    step(1'b1, 1'b1, 1'b0, {8{8'h02}});
    idle(22);
    // This load must land in row 0 (pointer untouched by ignored loads)
    step(1'b1, 1'b0, 1'b0, {8{8'h10}});
    step(1'b0, 1'b1, 1'b0, {8{8'h01}});
    idle(20);

    // Reset mid-computation, then a start with cleared weights
    step(1'b0, 1'b1, 1'b0, {8{8'h03}});
    idle(5);
    reset_mid();
    step(1'b0, 1'b1, 1'b0, {8{8'h07}});
    idle(20);

    // Random weights and traffic
    for (int r = 0; r < 8; r++) step(1'b1, 1'b0, 1'b0, {$urandom, $urandom});
    for (int k = 0; k < 400; k++)
      step(($urandom % 8) == 0, ($urandom % 2) == 0, ($urandom % 4) == 0,
           {$urandom, $urandom});

    // Drain with a bounded wait
    for (int k = 0; k < 100 && (sb.size() != 0 || m_stamps.size() != 0); k++) idle(1);
    chk("drain_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
